hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their write enables, flushes and bubble inserts. It covers three hazards:
- load-use data hazards, detected in ID;
- taken branches, resolved in EX;
- multi-cycle data-memory accesses, which use a request/ready handshake with a bounded timeout.

It also keeps saturating stall and flush performance counters.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/sat_counter.sv | 13 +
 rtl/hazard_ctrl.sv | 89 ++++++++
 tb/tb_hazard_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline types, NOP control words and hazard helpers.
package cpu_pkg;
  typedef enum logic {RUN, MEM_WAIT} hazard_state_t;
  localparam logic [1:0] NOP_WB = 2'b00;
  localparam logic [1:0] NOP_M  = 2'b00;
  localparam logic [3:0] NOP_EX = 4'b0000;
  function automatic logic reads_reg(input logic uses, input logic [4:0] src, input logic [4:0] dst);
    return uses && (src == dst);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at its maximum value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, taken-branch and slow-memory hazard control for the 5-stage pipeline.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IDRsAddr,
  input  logic [4:0]       IDRtAddr,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic             EXMemRead,
  input  logic [4:0]       EXRtAddr,
  input  logic             BranchTaken,
  input  logic             MemAccess,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             MEMWBBubble,
  output logic             MemError,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  hazard_state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic memstall, loaduse;
  assign memstall = MemAccess && !MemReady;
  assign loaduse  = EXMemRead && (EXRtAddr != 5'd0) &&
                    (reads_reg(IDUsesRs, IDRsAddr, EXRtAddr) || reads_reg(IDUsesRt, IDRtAddr, EXRtAddr));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
    end
  // Reset forces the default outputs regardless of the hazard inputs.
  always_comb begin
    state_n     = state;
    wait_n      = wait_cnt;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    EXMEMWrite  = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXBubble  = 1'b0;
    MEMWBBubble = 1'b0;
    MemError    = 1'b0;
    if (!rst)
      case (state)
        RUN:
          if (memstall) begin
            {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite} = 4'b0000;
            MEMWBBubble = 1'b1;
            state_n     = MEM_WAIT;
            wait_n      = WW'(1);
          end else if (BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
          end else if (loaduse) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
          end
        MEM_WAIT:
          if (MemReady) state_n = RUN;
          else if (wait_cnt < WW'(MEM_TIMEOUT)) begin
            {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite} = 4'b0000;
            MEMWBBubble = 1'b1;
            wait_n      = wait_cnt + WW'(1);
          end else begin
            MemError    = 1'b1;
            MEMWBBubble = 1'b1;
            state_n     = RUN;
          end
        default: state_n = RUN;
      endcase
  end
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(!PCWrite),  .count(StallCycles));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(IFIDFlush), .count(FlushCount));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;
  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  // Control word order: {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXBubble, MEMWBBubble, MemError}
  localparam logic [7:0] DEF = 8'b1111_0000;
  localparam logic [7:0] FRZ = 8'b0000_0010;
  localparam logic [7:0] BR  = 8'b1111_1100;
  localparam logic [7:0] LU  = 8'b0011_0100;
  localparam logic [7:0] TOE = 8'b1111_0011;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs = '0, rt = '0, exrt = '0;
  logic urs = 1'b0, urt = 1'b0, exmr = 1'b0, bt = 1'b0, ma = 1'b0, mr = 1'b0;
  logic pcw, ifidw, idexw, exmemw, flush, idexb, memwbb, merr;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int vectors = 0, errors = 0;
  int m_frozen = 0, m_stall = 0, m_flush = 0;
  logic [7:0] act, exp_ctl;
  logic lu;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .IDRsAddr(rs), .IDRtAddr(rt), .IDUsesRs(urs), .IDUsesRt(urt),
    .EXMemRead(exmr), .EXRtAddr(exrt), .BranchTaken(bt),
    .MemAccess(ma), .MemReady(mr),
    .PCWrite(pcw), .IFIDWrite(ifidw), .IDEXWrite(idexw), .EXMEMWrite(exmemw),
    .IFIDFlush(flush), .IDEXBubble(idexb), .MEMWBBubble(memwbb), .MemError(merr),
    .StallCycles(stall_cnt), .FlushCount(flush_cnt)
  );

  always #5 clk = ~clk;

  assign act = {pcw, ifidw, idexw, exmemw, flush, idexb, memwbb, merr};
  assign lu  = exmr && exrt != 0 && ((urs && exrt == rs) || (urt && exrt == rt));
  // m_frozen is the length of the current run of frozen cycles; nonzero means a memory access is pending.
  assign exp_ctl = rst ? DEF :
                   (m_frozen == 0) ? ((ma && !mr) ? FRZ : bt ? BR : lu ? LU : DEF) :
                   mr ? DEF : (m_frozen < TO) ? FRZ : TOE;

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_frozen <= 0;
      m_stall  <= 0;
      m_flush  <= 0;
    end else begin
      m_frozen <= (exp_ctl == FRZ) ? m_frozen + 1 : 0;
      if (!exp_ctl[7]) m_stall <= (m_stall < CMAX) ? m_stall + 1 : m_stall;
      if (exp_ctl[3])  m_flush <= (m_flush < CMAX) ? m_flush + 1 : m_flush;
    end

  task automatic compare();
    vectors++;
    if (act !== exp_ctl) begin
      errors++;
      $display("FAIL ctl @%0t: got %b want %b", $time, act, exp_ctl);
    end
    if (int'(stall_cnt) != m_stall) begin
      errors++;
      $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, m_stall);
    end
    if (int'(flush_cnt) != m_flush) begin
      errors++;
      $display("FAIL flush_cnt @%0t: got %0d want %0d", $time, flush_cnt, m_flush);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic drive(input logic a_rst, input logic [4:0] a_rs, input logic [4:0] a_rt,
                       input logic a_urs, input logic a_urt, input logic a_exmr, input logic [4:0] a_exrt,
                       input logic a_bt, input logic a_ma, input logic a_mr);
    @(posedge clk);
    #1;
    rst = a_rst; rs = a_rs; rt = a_rt; urs = a_urs; urt = a_urt;
    exmr = a_exmr; exrt = a_exrt; bt = a_bt; ma = a_ma; mr = a_mr;
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  initial begin
    logic slow;
    // Hazard inputs active during reset must not leak to the outputs.
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("reset_ctl", int'(act), int'(DEF));
    chk("reset_stall", int'(stall_cnt), 0);
    idle();
    // Load-use on Rs.
    drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_ctl", int'(act), int'(8'b0011_0100));
    idle();
    chk("lu_stall", int'(stall_cnt), 1);
    // Register 0 never stalls.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("r0_pcw", int'(pcw), 1);
    // Load-use on Rt only.
    drive(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("lu_rt_idexb", int'(idexb), 1);
    // Matching address but Rs not used.
    drive(1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("unused_rs_pcw", int'(pcw), 1);
    // Branch beats load-use.
    drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("br_ctl", int'(act), int'(8'b1111_1100));
    idle();
    chk("br_flush", int'(flush_cnt), 1);
    chk("br_stall", int'(stall_cnt), 2);
    // Memory wait: three frozen cycles then release.
    do_reset();
    repeat (3) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("mw_frz", int'(act), int'(8'b0000_0010));
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("mw_release", int'(act), int'(8'b1111_0000));
    idle();
    chk("mw_stall", int'(stall_cnt), 3);
    // Timeout: eight frozen cycles, then a one-cycle error with enables high.
    do_reset();
    repeat (8) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("to_last_frz", int'(pcw), 0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("to_err", int'(act), int'(8'b1111_0011));
    idle();
    chk("to_err_gone", int'(merr), 0);
    chk("to_stall", int'(stall_cnt), 8);
    // Freeze wins over branch; flush follows the release.
    do_reset();
    repeat (2) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      chk("sb_noflush", int'(flush), 0);
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    chk("sb_release", int'(act), int'(8'b1111_0000));
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("sb_flush", int'(flush), 1);
    // Reset in MEM_WAIT aborts immediately.
    do_reset();
    repeat (3) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("rst_wait_ctl", int'(act), int'(8'b1111_0000));
    chk("rst_wait_stall", int'(stall_cnt), 0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("rst_wait_refreeze", int'(pcw), 0);
    // Saturation.
    do_reset();
    repeat (20) drive(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    idle();
    chk("sat_stall", int'(stall_cnt), 15);
    // Randomized traffic with bursts of slow memory.
    slow = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 40 == 0) slow = ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 149) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
            slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
